// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, load FSM states, response error codes
// and the latched-request payload.
package ysyx_22050243_lsu_pkg;

  localparam int unsigned LSU_XLEN   = 64;
  localparam int unsigned LSU_ADDR_W = 64;
  localparam int unsigned OFF_W      = 3;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned ERR_W      = 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LD  = 3'b011;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;
  localparam logic [F3_W-1:0] F3_LWU = 3'b110;
  localparam logic [F3_W-1:0] F3_ILL = 3'b111;

  localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 2'd1;
  localparam logic [ERR_W-1:0] ERR_BUS      = 2'd2;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } load_state_e;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [F3_W-1:0]  funct3;
    logic [RD_W-1:0]  rd;
  } load_req_t;

  // funct3[1:0] is the access size: 0 byte, 1 half, 2 word, 3 dword.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      2'b11:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050243_load_ctrl_if.sv
// Request, data-memory read and writeback-response signals of the load controller.
// The controller connects through the slave modport; the environment uses master.
interface ysyx_22050243_load_ctrl_if #(
  parameter int unsigned XLEN   = ysyx_22050243_lsu_pkg::LSU_XLEN,
  parameter int unsigned ADDR_W = ysyx_22050243_lsu_pkg::LSU_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [4:0]        req_rd;

  logic              mem_arvalid;
  logic              mem_arready;
  logic [ADDR_W-1:0] mem_araddr;
  logic              mem_rvalid;
  logic              mem_rready;
  logic [XLEN-1:0]   mem_rdata;
  logic [1:0]        mem_rresp;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_err;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd,
    output req_ready,
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output resp_valid, resp_data, resp_rd, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd,
    input  req_ready,
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  resp_valid, resp_data, resp_rd, resp_err,
    output resp_ready
  );

endinterface

// File: rtl/ysyx_22050243_load_align.sv
// Lane select and sign/zero extension of an aligned 8-byte beat for RV64 loads.
module ysyx_22050243_load_align
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [F3_W-1:0]  funct3,
  output logic [XLEN-1:0]  data_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data_c  = '0;
    case (funct3)
      F3_LB:   data_c = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   data_c = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   data_c = shifted;
      F3_LBU:  data_c = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_LHU:  data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  data_c = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_load_ctrl.sv
// RV64 LSU load controller: one outstanding load, aligned memory read, lane extract,
// registered WBU response. YSYX_22050243_LOAD_PERF_EN adds a saturating stall counter.
module ysyx_22050243_load_ctrl
  import ysyx_22050243_lsu_pkg::*;
#(
  parameter int unsigned XLEN   = LSU_XLEN,
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_22050243_load_ctrl_if.slave bus
`ifdef YSYX_22050243_LOAD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  load_state_e     state;
  load_req_t       req_q;
  logic [XLEN-1:0] aligned_c;

  ysyx_22050243_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (bus.mem_rdata),
    .offset (req_q.off),
    .funct3 (req_q.funct3),
    .data_c (aligned_c)
  );

  // Control FSM; every bus output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      req_q           <= '0;
      bus.req_ready   <= 1'b1;
      bus.mem_arvalid <= 1'b0;
      bus.mem_araddr  <= '0;
      bus.mem_rready  <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_rd     <= '0;
      bus.resp_err    <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_q.off     <= bus.req_addr[OFF_W-1:0];
            req_q.funct3  <= bus.req_funct3;
            req_q.rd      <= bus.req_rd;
            bus.req_ready <= 1'b0;
            // Illegal and misaligned loads answer directly without touching memory.
            if (bus.req_funct3 == F3_ILL) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_rd    <= bus.req_rd;
              bus.resp_err   <= ERR_ILLEGAL;
            end else if (is_misaligned(bus.req_funct3[1:0], bus.req_addr[OFF_W-1:0])) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_rd    <= bus.req_rd;
              bus.resp_err   <= ERR_MISALIGN;
            end else begin
              state           <= S_ADDR;
              bus.mem_arvalid <= 1'b1;
              bus.mem_araddr  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            end
          end
        end
        S_ADDR: begin
          if (bus.mem_arready) begin
            state           <= S_DATA;
            bus.mem_arvalid <= 1'b0;
            bus.mem_rready  <= 1'b1;
          end
        end
        S_DATA: begin
          if (bus.mem_rvalid) begin
            state          <= S_RESP;
            bus.mem_rready <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rd    <= req_q.rd;
            if (bus.mem_rresp != 2'd0) begin
              bus.resp_data <= '0;
              bus.resp_err  <= ERR_BUS;
            end else begin
              bus.resp_data <= aligned_c;
              bus.resp_err  <= ERR_NONE;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state          <= S_IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef YSYX_22050243_LOAD_PERF_EN
  logic stall_c;

  assign stall_c = ((state == S_ADDR) && !bus.mem_arready) ||
                   ((state == S_DATA) && !bus.mem_rvalid);

  // Memory-side stall cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (stall_c && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ysyx_22050243_load_ctrl.md
Name: ysyx_22050243_load_ctrl

Overview:
Load-path controller for the RV64 LSU. Accepts one load at a time from EXU, issues an 8-byte-aligned read to the data-memory port, and selects the addressed byte/half/word/dword lane. It then drives the lane through a sign/zero-extend stage chosen by funct3 and returns the XLEN result to WBU over a valid/ready handshake. Misaligned or illegal loads are reported without any memory access.

Parameters:
XLEN, 64, data width of result and memory beat
ADDR_W, 64, load address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  load request valid
req_ready  out  1  controller can accept request
req_addr  in  ADDR_W  byte address
req_funct3  in  3  RV load funct3
req_rd  in  5  destination register tag
mem_arvalid  out  1  read address valid
mem_arready  in  1  memory accepts address
mem_araddr  out  ADDR_W  req_addr with low 3 bits cleared
mem_rvalid  in  1  read data valid
mem_rready  out  1  controller accepts data
mem_rdata  in  XLEN  aligned 8-byte beat
mem_rresp  in  2  0 = OK, nonzero = bus error
resp_valid  out  1  result valid
resp_ready  in  1  WBU accepts result
resp_data  out  XLEN  extended load result
resp_rd  out  5  tag of completed load
resp_err  out  2  0 none, 1 misaligned, 2 bus error, 3 illegal funct3

Behaviour:
- Single clock domain. All state is reset when rst_n=0 is sampled at a clk edge. Reset mid-transaction abandons the load; the memory side must be reset together with this block.
- Reset values: state=IDLE, req_ready=1, mem_arvalid=0, mem_rready=0, resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
- FSM states are IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1. When req_valid is high, latch addr, funct3 and rd.
  - funct3=111 -> RESP with err=3, data=0.
  - Misaligned -> RESP with err=1, data=0. Misaligned means half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - Otherwise -> ADDR.
- ADDR: mem_arvalid=1 and mem_araddr held stable until mem_arready. On the handshake cycle, go to DATA.
- DATA: mem_rready=1. On mem_rvalid:
  - rresp!=0 -> RESP with err=2, data=0.
  - Otherwise, shift mem_rdata right by 8*addr[2:0] and extend:
    - LB/LH/LW: sign-extend from bit 7/15/31.
    - LBU/LHU/LWU: zero-extend.
    - LD: pass through.
  - Go to RESP.
- RESP: resp_valid=1. resp_data, rd and err are registered and held stable until resp_ready. On the handshake cycle, go to IDLE. req_ready stays 0 until the next cycle, so there is no same-cycle back-to-back acceptance.
- Latency: minimum 3 cycles from request acceptance to resp_valid, with zero-wait memory (ADDR, DATA, RESP each 1 cycle). Error paths take 1 cycle to resp_valid.
- Backpressure: any number of stall cycles in ADDR, DATA or RESP leaves outputs unchanged.
- mem_rvalid asserted outside DATA is ignored. Memory must not present data before the address handshake.
- req_ready is 0 in every state except IDLE.

Optional Feature:
YSYX_22050243_LOAD_PERF_EN
- Defined: adds output port perf_stall_cnt (32 bits), reset to 0. It increments each cycle the FSM is in ADDR with !mem_arready, or in DATA with !mem_rvalid. It saturates at 0xFFFF_FFFF.
- Undefined: port and counter absent; function otherwise identical.

Decomposition:
- Shared package ysyx_22050243_lsu_pkg holds:
  - funct3 constants: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - FSM state encoding.
  - resp_err codes.
- One sub-module: ysyx_22050243_load_align. It is purely combinational lane shift plus width-select sign/zero extension, taking aligned data, offset and funct3 and returning XLEN. The result register stays in the controller.

Test Plan:
- LB, addr 0x8000_0003, rdata 0x0000_0000_8000_0000 -> resp_data 0xFFFF_FFFF_FFFF_FF80, err 0, araddr 0x8000_0000.
- LHU, addr 0x8000_0006, rdata 0xBEEF_0000_0000_0000 -> resp_data 0x0000_0000_0000_BEEF. Also LWU, addr 0x8000_0004, rdata 0x8765_4321_0000_0000 -> resp_data 0x0000_0000_8765_4321.
- LW at addr 0x8000_0002 -> err 1 after 1 cycle, mem_arvalid never asserted; funct3 111 -> err 3.
- LD with arready delayed 4 cycles, rvalid delayed 2, resp_ready delayed 3 -> outputs stable throughout, resp_data equals rdata. With YSYX_22050243_LOAD_PERF_EN defined, perf_stall_cnt=6.
- rresp=2 on LD -> err 2, data 0. Then an immediate follow-on LBU completes normally.
- rst_n low for 1 cycle while in DATA -> next cycle IDLE, all outputs at reset values, and a fresh LW completes correctly.
